// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier, divider).
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of an iteration counter covering 0..w-1; never narrower than 1 bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_rca.sv
// Ripple-carry adder: WIDTH-bit sum with carry-in and carry-out.
module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Bit-serial carry chain from LSB to MSB.
  always_comb begin
    logic c;
    o_sum = '0;
    c     = i_cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier: one adder reused for WIDTH
// iterations, start/busy/done handshake, product held until the next DONE.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = cnt_width(WIDTH);

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // Partial-product select: add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    w_addend = r_lo[0] ? r_mcand : '0;
  end

  ripple_carry_adder #(
    .WIDTH(WIDTH)
  ) u_add (
    .i_a    (r_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Control FSM plus shift registers; busy/done/P are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= A;
            r_hi    <= '0;
            r_lo    <= B;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_hi    <= {w_cout, w_sum[WIDTH-1:1]};
          r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            // Final shifted value is written straight to P so it is valid with done.
            r_p     <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: cycle-level reference model with a
// product scoreboard, directed cases plus randomized operands.
module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*W-1:0] sb[$];

  // Reference model state
  int             m_rem   = 0;
  logic           m_busy  = 1'b0;
  logic           m_done  = 1'b0;
  logic [2*W-1:0] m_hold  = '0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned x, y;
    x = a;
    y = b;
    return x * y;
  endfunction

  // Reference model: a captured operation takes W cycles, then done for one cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_rem  = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hold = '0;
      sb.delete();
    end else if (m_busy) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        if (sb.size() > 0) m_hold = sb[0];
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        sb.push_back(ref_mul(A, B));
        m_busy = 1'b1;
        m_rem  = W;
      end
    end
  end

  // Monitor: compare handshake every cycle, pop the scoreboard on each done.
  always @(negedge clk) begin
    logic [2*W-1:0] exp_p;
    n_cmp++;
    if (busy !== m_busy) begin
      n_bad++;
      $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, m_busy);
    end
    n_cmp++;
    if (done !== m_done) begin
      n_bad++;
      $display("FAIL done t=%0t got=%b exp=%b", $time, done, m_done);
    end
    if (done === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL product t=%0t got=%h exp=<no pending op>", $time, P);
      end else begin
        exp_p = sb.pop_front();
        if (P !== exp_p) begin
          n_bad++;
          $display("FAIL product t=%0t got=%h exp=%h", $time, P, exp_p);
        end
      end
    end
    n_cmp++;
    if (P !== m_hold) begin
      n_bad++;
      $display("FAIL p_hold t=%0t got=%h exp=%h", $time, P, m_hold);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One operation; optional stray start (with new operands) at RUN cycle `poke`.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      if (c == poke) begin
        start = 1'b1;
        A = $urandom;
        B = $urandom;
        tick();
        start = 1'b0;
        A = $urandom;
        B = $urandom;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    tick(2);
    reset = 1'b0;
    tick();

    // Directed cases
    do_op(32'd3, 32'd5, 0);
    tick(3);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(32'd0, 32'h1234_5678, 0);
    do_op(32'd1, 32'h8000_0000, 0);
    do_op(32'd41242, 32'd312323, 0);
    do_op(32'd7, 32'd6, 10);

    // Reset at RUN cycle 15 discards the operation
    A = 32'd100;
    B = 32'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(14);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(2);
    do_op(32'd100, 32'd200, 0);

    // Back-to-back with start held high, operands switched in the DONE cycle
    A = 32'd2;
    B = 32'd3;
    start = 1'b1;
    tick();
    tick(W);
    A = 32'd4;
    B = 32'd5;
    tick();
    start = 1'b0;
    tick(W + 3);

    // Randomized operands, with corner values mixed in and occasional stray starts
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = '0;
        2: ra = 32'd1;
        default: ;
      endcase
      do_op(ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W - 1)) : 0);
      tick($urandom_range(0, 2));
    end

    tick(4);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
